// File: rtl/i2c_apb_regfile.sv
// APB register file and show-ahead TX FIFO feeding an i2c_controller.
// CTRL/ADDR/STATUS registers plus a DEPTH-entry byte FIFO; the controller
// sees the FIFO head on data_in and consumes it with a one-cycle tx_pop.
module i2c_apb_regfile #(
    parameter int DEPTH = 4
) (
    input  logic       core_clk,
    input  logic       rst_n,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    input  logic       tx_pop,
    output logic       enable,
    output logic [7:0] slave_address,
    output logic [7:0] data_in,
    output logic       repeated_start_cond
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_ADDR   = 8'h04;
    localparam logic [7:0] A_TXDATA = 8'h08;
    localparam logic [7:0] A_STATUS = 8'h0C;

    // Count shown in STATUS[7:4] saturates at 15 for deep FIFOs.
    function automatic logic [3:0] sat_cnt(input logic [CW-1:0] c);
        logic [31:0] v;
        v = 32'(c);
        return (v > 32'd15) ? 4'hF : v[3:0];
    endfunction

    logic          ctrl_en_q, ctrl_en_d;
    logic          ctrl_rs_q, ctrl_rs_d;
    logic [7:0]    addr_q, addr_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          enable_q, enable_d;
    logic          rstart_q, rstart_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];

    logic access, wr_acc, addr_ok;
    logic sel_ctrl, sel_addr, sel_tx, sel_stat;
    logic empty, full, pop_ok, push_req, push_drop, push_ok, flush;
    logic [7:0] status;

    // APB decode and FIFO push/pop arbitration for the current cycle.
    always_comb begin
        access    = psel & penable;
        wr_acc    = access & pwrite;
        sel_ctrl  = (paddr == A_CTRL);
        sel_addr  = (paddr == A_ADDR);
        sel_tx    = (paddr == A_TXDATA);
        sel_stat  = (paddr == A_STATUS);
        addr_ok   = sel_ctrl | sel_addr | sel_tx | sel_stat;
        empty     = (cnt_q == '0);
        full      = (cnt_q == CW'(DEPTH));
        // A pop against an empty FIFO is ignored, including when a push
        // arrives in the same cycle.
        pop_ok    = tx_pop & ~empty;
        push_req  = wr_acc & sel_tx;
        // A full FIFO only accepts a push if a byte leaves in the same cycle.
        push_drop = push_req & full & ~pop_ok;
        push_ok   = push_req & ~push_drop;
        flush     = wr_acc & sel_ctrl & pwdata[7];
        status    = {sat_cnt(cnt_q), 1'b0, ovf_q, full, empty};
    end

    // APB response: zero wait states, reads straight from register state.
    always_comb begin
        pready  = access;
        pslverr = access & (~addr_ok | push_drop);
        prdata  = 8'h00;
        if (access) begin
            if (sel_ctrl)      prdata = {6'b0, ctrl_rs_q, ctrl_en_q};
            else if (sel_addr) prdata = addr_q;
            else if (sel_stat) prdata = status;
        end
    end

    // Next-state for registers, FIFO storage and controller-facing outputs.
    always_comb begin
        ctrl_en_d = ctrl_en_q;
        ctrl_rs_d = ctrl_rs_q;
        addr_d    = addr_q;
        ovf_d     = ovf_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        mem_d     = mem_q;
        if (wr_acc & sel_ctrl) begin
            ctrl_en_d = pwdata[0];
            ctrl_rs_d = pwdata[1];
        end
        if (wr_acc & sel_addr) addr_d = pwdata;
        if (push_drop)
            ovf_d = 1'b1;
        else if (wr_acc & sel_stat & pwdata[2])
            ovf_d = 1'b0;
        // Flush wins over any pop in the same cycle.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = pwdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
        enable_d = ctrl_en_q & ~empty;
        rstart_d = ctrl_rs_q;
    end

    // Control state with asynchronous reset.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en_q <= 1'b0;
            ctrl_rs_q <= 1'b0;
            addr_q    <= 8'h00;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            enable_q  <= 1'b0;
            rstart_q  <= 1'b0;
        end else begin
            ctrl_en_q <= ctrl_en_d;
            ctrl_rs_q <= ctrl_rs_d;
            addr_q    <= addr_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            enable_q  <= enable_d;
            rstart_q  <= rstart_d;
        end
    end

    // FIFO byte storage; contents are only meaningful under the count.
    always_ff @(posedge core_clk) begin
        mem_q <= mem_d;
    end

    assign enable              = enable_q;
    assign repeated_start_cond = rstart_q;
    assign slave_address       = addr_q;
    assign data_in             = empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_i2c_apb_regfile.sv
// Directed bench for i2c_apb_regfile (DEPTH=4).
module tb_i2c_apb_regfile;

    logic       core_clk;
    logic       rst_n;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata;
    logic       pready, pslverr;
    logic       tx_pop;
    logic       enable;
    logic [7:0] slave_address, data_in;
    logic       repeated_start_cond;

    int vectors = 0;
    int miscompares = 0;

    i2c_apb_regfile #(.DEPTH(4)) dut (
        .core_clk(core_clk),
        .rst_n(rst_n),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr),
        .tx_pop(tx_pop),
        .enable(enable),
        .slave_address(slave_address),
        .data_in(data_in),
        .repeated_start_cond(repeated_start_cond)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer; optional tx_pop held high during the access phase.
    task automatic apb(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic pop, output logic [7:0] rd, output logic err);
        @(negedge core_clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge core_clk);
        penable = 1'b1; tx_pop = pop;
        #1;
        rd  = prdata;
        err = pslverr;
        @(posedge core_clk);
        @(negedge core_clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_pop = 1'b0;
    endtask

    task automatic pop_once();
        @(negedge core_clk);
        tx_pop = 1'b1;
        @(negedge core_clk);
        tx_pop = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rd;
        logic       err;
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; tx_pop = 0;
        rst_n = 1'b0;

        // Reset defaults
        #40;
        chk("rst_enable", {7'b0, enable}, 8'h00);
        chk("rst_data_in", data_in, 8'h00);
        chk("rst_slave_address", slave_address, 8'h00);
        chk("rst_pready", {7'b0, pready}, 8'h00);
        chk("rst_prdata", prdata, 8'h00);
        #40;
        rst_n = 1'b1;
        apb(0, 8'h00, 0, 0, rd, err); chk("rst_ctrl", rd, 8'h00);
        apb(0, 8'h04, 0, 0, rd, err); chk("rst_addr", rd, 8'h00);
        apb(0, 8'h0C, 0, 0, rd, err); chk("rst_status", rd, 8'h01);
        chk("rst_rstart", {7'b0, repeated_start_cond}, 8'h00);

        // Basic programming
        apb(1, 8'h04, 8'hF0, 0, rd, err);
        chk("slave_address", slave_address, 8'hF0);
        apb(1, 8'h08, 8'h01, 0, rd, err);
        chk("data_in_first", data_in, 8'h01);
        apb(1, 8'h00, 8'h01, 0, rd, err);
        chk("enable_one_edge", {7'b0, enable}, 8'h00);
        @(negedge core_clk);
        chk("enable_two_edges", {7'b0, enable}, 8'h01);
        apb(0, 8'h0C, 0, 0, rd, err); chk("status_one_byte", rd, 8'h10);

        // Drain the single byte: enable falls one edge after the last pop
        pop_once();
        chk("data_in_empty", data_in, 8'h00);
        chk("enable_lag", {7'b0, enable}, 8'h01);
        @(negedge core_clk);
        chk("enable_fall", {7'b0, enable}, 8'h00);

        // Fill and wrap
        apb(1, 8'h08, 8'hA1, 0, rd, err);
        apb(1, 8'h08, 8'hA2, 0, rd, err);
        apb(1, 8'h08, 8'hA3, 0, rd, err);
        apb(1, 8'h08, 8'hA4, 0, rd, err);
        chk("push4_err", {7'b0, err}, 8'h00);
        apb(0, 8'h0C, 0, 0, rd, err); chk("status_full", rd, 8'h42);
        apb(1, 8'h08, 8'hA5, 0, rd, err);
        chk("overflow_err", {7'b0, err}, 8'h01);
        apb(0, 8'h0C, 0, 0, rd, err); chk("status_ovf", rd, 8'h46);
        chk("head_a1", data_in, 8'hA1);
        pop_once(); chk("head_a2", data_in, 8'hA2);
        pop_once(); chk("head_a3", data_in, 8'hA3);
        pop_once(); chk("head_a4", data_in, 8'hA4);
        pop_once(); chk("head_empty", data_in, 8'h00);
        apb(0, 8'h0C, 0, 0, rd, err); chk("status_empty_ovf", rd, 8'h05);
        chk("enable_after_drain", {7'b0, enable}, 8'h00);
        apb(1, 8'h0C, 8'h04, 0, rd, err);
        apb(0, 8'h0C, 0, 0, rd, err); chk("status_ovf_clear", rd, 8'h01);

        // Simultaneous push/pop while full
        apb(1, 8'h08, 8'h11, 0, rd, err);
        apb(1, 8'h08, 8'h22, 0, rd, err);
        apb(1, 8'h08, 8'h33, 0, rd, err);
        apb(1, 8'h08, 8'h44, 0, rd, err);
        apb(1, 8'h08, 8'hB5, 1, rd, err);
        chk("full_pushpop_err", {7'b0, err}, 8'h00);
        apb(0, 8'h0C, 0, 0, rd, err); chk("full_pushpop_status", rd, 8'h42);
        chk("full_pushpop_head", data_in, 8'h22);
        pop_once(); pop_once(); pop_once();
        chk("tail_b5", data_in, 8'hB5);
        pop_once();
        chk("empty_again", data_in, 8'h00);

        // Simultaneous push/pop while empty
        apb(1, 8'h08, 8'hC6, 1, rd, err);
        chk("empty_pushpop_err", {7'b0, err}, 8'h00);
        apb(0, 8'h0C, 0, 0, rd, err); chk("empty_pushpop_status", rd, 8'h10);
        chk("empty_pushpop_head", data_in, 8'hC6);

        // Bad address
        apb(0, 8'h10, 0, 0, rd, err); chk("badaddr_rd_err", {7'b0, err}, 8'h01);
        apb(1, 8'h10, 8'hFF, 0, rd, err); chk("badaddr_wr_err", {7'b0, err}, 8'h01);
        apb(0, 8'h0C, 0, 0, rd, err); chk("badaddr_status", rd, 8'h10);
        apb(0, 8'h04, 0, 0, rd, err); chk("badaddr_addr", rd, 8'hF0);
        apb(0, 8'h00, 0, 0, rd, err); chk("badaddr_ctrl", rd, 8'h01);

        // Repeated start
        apb(1, 8'h00, 8'h03, 0, rd, err);
        @(negedge core_clk);
        chk("rstart_set", {7'b0, repeated_start_cond}, 8'h01);
        apb(0, 8'h00, 0, 0, rd, err); chk("ctrl_03", rd, 8'h03);

        // Flush with three bytes queued
        apb(1, 8'h08, 8'hD1, 0, rd, err);
        apb(1, 8'h08, 8'hD2, 0, rd, err);
        apb(0, 8'h0C, 0, 0, rd, err); chk("status_three", rd, 8'h30);
        chk("enable_three", {7'b0, enable}, 8'h01);
        apb(1, 8'h00, 8'h81, 0, rd, err);
        apb(0, 8'h0C, 0, 0, rd, err); chk("flush_status", rd, 8'h01);
        chk("flush_data_in", data_in, 8'h00);
        chk("flush_enable", {7'b0, enable}, 8'h00);
        apb(0, 8'h00, 0, 0, rd, err); chk("flush_ctrl_selfclear", rd, 8'h01);

        // Reset mid-transfer
        apb(1, 8'h08, 8'hE1, 0, rd, err);
        apb(1, 8'h08, 8'hE2, 0, rd, err);
        @(negedge core_clk);
        chk("pre_reset_enable", {7'b0, enable}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("midrst_enable", {7'b0, enable}, 8'h00);
        chk("midrst_data_in", data_in, 8'h00);
        chk("midrst_slave_address", slave_address, 8'h00);
        chk("midrst_rstart", {7'b0, repeated_start_cond}, 8'h00);
        @(negedge core_clk);
        rst_n = 1'b1;
        apb(0, 8'h0C, 0, 0, rd, err); chk("midrst_status", rd, 8'h01);
        apb(0, 8'h00, 0, 0, rd, err); chk("midrst_ctrl", rd, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
